// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - INTA pulse sequencer: level freeze, cascade address, vector bytes, ISR strobes
module inta_sequencer #(
   parameter int          IRQ_N       = 8,
   parameter logic [7:0]  CALL_OPCODE = 8'hCD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inta_n,
   input  logic             int_req,
   input  logic [2:0]       irr_id,
   input  logic             sngl,
   input  logic             sp_en,
   input  logic [7:0]       icw3,
   input  logic             upm,
   input  logic             aeoi,
   input  logic [4:0]       vec_base,
   input  logic [7:0]       addr_hi,
   input  logic [2:0]       addr_lo,
   input  logic [2:0]       cas_in,
   output logic             intr,
   output logic [2:0]       cas_out,
   output logic             cas_oe,
   output logic [7:0]       d_out,
   output logic             d_oe,
   output logic [IRQ_N-1:0] isr_set,
   output logic [IRQ_N-1:0] isr_clr,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t     state;
   logic       inta_q;
   logic [1:0] cnt;
   logic [2:0] id_l;
   logic       spur_l, upm_l, sel_l;

   logic       fall, rise;
   logic       spur_n, cm_n, sel_n;
   logic [2:0] id_n;
   logic [1:0] last;
   logic [1:0] cnt_inc;

   assign fall    = inta_q & ~inta_n;
   assign rise    = ~inta_q & inta_n;
   assign spur_n  = ~int_req;
   assign id_n    = spur_n ? 3'd7 : irr_id;
   assign cm_n    = sp_en & ~sngl & icw3[id_n];
   assign sel_n   = sngl | (sp_en & ~cm_n) | (~sp_en & (cas_in == icw3[2:0]));
   assign last    = upm_l ? 2'd2 : 2'd3;
   assign cnt_inc = cnt + 2'd1;

   // 8086 leaves the bus floating on its first pulse
   function automatic logic drives(input logic [1:0] n, input logic m86);
      return !(m86 && n == 2'd1);
   endfunction

   function automatic logic [7:0] pulse_byte(input logic [1:0] n, input logic m86,
                                             input logic [2:0] id);
      if (m86)
         return {vec_base, id};
      case (n)
         2'd1:    return CALL_OPCODE;
         2'd2:    return {addr_lo, id, 2'b00};
         default: return addr_hi;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         inta_q  <= 1'b1;
         cnt     <= '0;
         id_l    <= '0;
         spur_l  <= 1'b0;
         upm_l   <= 1'b0;
         sel_l   <= 1'b0;
         intr    <= 1'b0;
         cas_out <= '0;
         cas_oe  <= 1'b0;
         d_out   <= '0;
         d_oe    <= 1'b0;
         isr_set <= '0;
         isr_clr <= '0;
         busy    <= 1'b0;
      end else begin
         inta_q  <= inta_n;
         isr_set <= '0;
         isr_clr <= '0;
         case (state)
            IDLE: begin
               intr <= int_req;
               if (fall) begin
                  state   <= LOW;
                  cnt     <= 2'd1;
                  id_l    <= id_n;
                  spur_l  <= spur_n;
                  upm_l   <= upm;
                  sel_l   <= sel_n;
                  intr    <= 1'b0;
                  busy    <= 1'b1;
                  if (!spur_n)
                     isr_set <= IRQ_N'(1) << irr_id;
                  cas_oe  <= cm_n;
                  cas_out <= cm_n ? id_n : 3'd0;
                  d_oe    <= sel_n & drives(2'd1, upm);
                  d_out   <= (sel_n & drives(2'd1, upm)) ? pulse_byte(2'd1, upm, id_n) : 8'd0;
               end
            end
            LOW: begin
               if (rise) begin
                  d_oe  <= 1'b0;
                  d_out <= '0;
                  if (cnt == last) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     intr    <= int_req;
                     cas_oe  <= 1'b0;
                     cas_out <= '0;
                     if (aeoi && !spur_l)
                        isr_clr <= IRQ_N'(1) << id_l;
                  end else begin
                     state <= HIGH;
                  end
               end
            end
            HIGH: begin
               if (fall) begin
                  state <= LOW;
                  cnt   <= cnt_inc;
                  d_oe  <= sel_l & drives(cnt_inc, upm_l);
                  d_out <= (sel_l & drives(cnt_inc, upm_l)) ? pulse_byte(cnt_inc, upm_l, id_l) : 8'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
